// File: rtl/seq_pager_pkg.sv
// Shared types and helpers for the serial pattern pager.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pager_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HUNT = 2'd2,
    S_PAGE = 2'd3
  } state_t;

  // Bits needed to hold a pattern length from 0 up to max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/pat_match_shift.sv
// History shift register, fill counter and length-masked compare against the pattern.
// Latency: hit is combinational on the bit being accepted; history updates on the edge.
// Backpressure: none; a bit is consumed whenever shift_en is high.
module pat_match_shift
  import seq_pager_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  output logic               full_next,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_nx;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W:0]     fill_inc;

  // Window including the bit being accepted, and a mask selecting the low pat_len bits.
  always_comb begin
    hist_nx  = {hist[MAX_LEN-2:0], x};
    fill_inc = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < pat_len);
    end
    // History counts as full once this accepted bit brings fill up to pat_len.
    full_next = shift_en && (fill_inc >= {1'b0, pat_len});
    hit       = full_next && (pat_len != '0) && ((hist_nx & mask) == (pat & mask));
  end

  // Shift in accepted bits; a clear (reconfig or non-overlap match) wins over the shift.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_nx;
      if (fill < pat_len) fill <= fill_inc[LEN_W-1:0];
    end
  end

endmodule

// File: rtl/seq_pager_param.sv
// Serial pattern pager: pulses z per match, counts matches, raises a sticky page at THRESH.
// Latency: z, match_cnt and page update on the edge that accepts the completing bit (1 cycle).
// Backpressure: none; every in_valid bit is consumed, cfg_we discards the bit of its cycle.
module seq_pager_param
  import seq_pager_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 4,
  parameter int THRESH  = 3,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               in_valid,
  input  logic               x,
  input  logic               ack,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               page,
  output logic               armed
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  state_t             state;
  state_t             state_nx;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic               hit;
  logic               full_next;
  logic               match;
  logic               shift_en;
  logic               clr_hist;
  logic               cfg_len_ok;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W-1:0]   cnt_nx;
  logic               page_nx;

  assign shift_en   = in_valid && !cfg_we;
  assign match      = hit && (state != S_IDLE);
  assign clr_hist   = cfg_we || (match && !ovl_r);
  assign cfg_len_ok = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

  pat_match_shift #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_hist),
    .shift_en  (shift_en),
    .x         (x),
    .pat       (pat_r),
    .pat_len   (len_r),
    .full_next (full_next),
    .hit       (hit)
  );

  // Next counter/page/state: ack clears first, then a match counts on top of the cleared value.
  always_comb begin
    cnt_base = ack ? '0 : match_cnt;
    page_nx  = ack ? 1'b0 : page;
    cnt_nx   = cnt_base;
    if (match) begin
      if (cnt_base != CNT_MAX) cnt_nx = cnt_base + CNT_W'(1);
      if (cnt_nx == THR) page_nx = 1'b1;
    end
    state_nx = state;
    case (state)
      S_IDLE: state_nx = S_IDLE;
      default: begin
        if (match && !ovl_r)                  state_nx = S_FILL;
        else if (state == S_FILL && !full_next) state_nx = S_FILL;
        else                                  state_nx = page_nx ? S_PAGE : S_HUNT;
      end
    endcase
    if (cfg_we) begin
      cnt_nx   = '0;
      page_nx  = 1'b0;
      state_nx = cfg_len_ok ? S_FILL : S_IDLE;
    end
  end

  // FSM state, configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pat_r     <= '0;
      len_r     <= '0;
      ovl_r     <= 1'b0;
      z         <= 1'b0;
      match_cnt <= '0;
      page      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nx;
      z         <= match;
      match_cnt <= cnt_nx;
      page      <= page_nx;
      armed     <= (state_nx == S_HUNT) || (state_nx == S_PAGE);
      if (cfg_we) begin
        pat_r <= pat;
        len_r <= pat_len;
        ovl_r <= overlap;
      end
    end
  end

endmodule

// File: tb/tb_seq_pager_param.sv
// Scoreboard bench for seq_pager_param (MAX_LEN=8, CNT_W=2, THRESH=3).
// Stimulus pushes the expected {page, match_cnt} for each bit that completes a match.
// A negedge monitor pops and compares whenever z is high.
module tb_seq_pager_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] pat = '0;
  logic [3:0] pat_len = '0;
  logic       overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic       x = 1'b0;
  logic       ack = 1'b0;
  logic       z;
  logic [1:0] match_cnt;
  logic       page;
  logic       armed;

  int tests = 0;
  int fails = 0;
  logic [2:0] sb[$];

  seq_pager_param #(.MAX_LEN(8), .CNT_W(2), .THRESH(3)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .pat(pat), .pat_len(pat_len),
    .overlap(overlap), .in_valid(in_valid), .x(x), .ack(ack),
    .z(z), .match_cnt(match_cnt), .page(page), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every z pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && z === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_z: got z=1 cnt=%0d page=%0b expected no pulse", match_cnt, page);
      end else begin
        logic [2:0] e;
        e = sb.pop_front();
        if ({page, match_cnt} !== e) begin
          fails++;
          $display("FAIL z_pulse: got page=%0b cnt=%0d expected page=%0b cnt=%0d",
                   page, match_cnt, e[2], e[1:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic a, input bit exp_z,
                      input logic [1:0] ec, input logic ep);
    x = b; in_valid = 1'b1; ack = a;
    if (exp_z) sb.push_back({ep, ec});
    cyc();
    in_valid = 1'b0; ack = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic with_bit);
    pat = p; pat_len = l; overlap = o; cfg_we = 1'b1;
    in_valid = with_bit; x = 1'b1;
    cyc();
    cfg_we = 1'b0; in_valid = 1'b0;
  endtask

  task automatic drained(input string name);
    cyc(); cyc();
    check(name, sb.size(), 0);
  endtask

  initial begin
    // Reset and idle with no configuration.
    rst_n = 1'b0; cyc(); cyc();
    check("rst_z", z, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_page", page, 0);
    check("rst_armed", armed, 0);
    rst_n = 1'b1;
    send(0,0,0,0,0); send(0,0,0,0,0); send(1,0,0,0,0); send(1,0,0,0,0);
    check("idle_cnt", match_cnt, 0);
    check("idle_armed", armed, 0);
    drained("idle_drain");

    // Basic match 0011.
    cfg(8'b0011, 4, 1, 0);
    send(0,0,0,0,0); send(0,0,0,0,0); send(1,0,0,0,0);
    check("basic_armed_pre", armed, 0);
    send(1,0,1,2'd1,0);
    check("basic_armed", armed, 1);
    check("basic_cnt", match_cnt, 1);
    drained("basic_drain");

    // Overlap on 1001 over 1,0,0,1,0,0,1.
    cfg(8'b1001, 4, 1, 0);
    send(1,0,0,0,0); send(0,0,0,0,0); send(0,0,0,0,0); send(1,0,1,2'd1,0);
    send(0,0,0,0,0); send(0,0,0,0,0); send(1,0,1,2'd2,0);
    check("ovl_cnt", match_cnt, 2);
    drained("ovl_drain");

    // Non-overlap: only the first match counts, history restarts.
    cfg(8'b1001, 4, 0, 0);
    send(1,0,0,0,0); send(0,0,0,0,0); send(0,0,0,0,0); send(1,0,1,2'd1,0);
    send(0,0,0,0,0); send(0,0,0,0,0); send(1,0,0,0,0);
    check("novl_cnt", match_cnt, 1);
    check("novl_armed", armed, 0);
    drained("novl_drain");

    // Page at third match, ack together with a fourth match, then plain ack.
    cfg(8'b01, 2, 1, 0);
    send(0,0,0,0,0); send(1,0,1,2'd1,0);
    send(0,0,0,0,0); send(1,0,1,2'd2,0);
    send(0,0,0,0,0); send(1,0,1,2'd3,1);
    check("page_set", page, 1);
    check("page_armed", armed, 1);
    send(0,0,0,0,0); send(1,1,1,2'd1,0);
    check("ackmatch_page", page, 0);
    check("ackmatch_cnt", match_cnt, 1);
    send(0,0,0,0,0); send(1,0,1,2'd2,0);
    send(0,0,0,0,0); send(1,0,1,2'd3,1);
    ack = 1'b1; cyc(); ack = 1'b0;
    check("ack_cnt", match_cnt, 0);
    check("ack_page", page, 0);
    check("ack_armed", armed, 1);
    drained("page_drain");

    // Saturation with a 1-bit pattern.
    cfg(8'b1, 1, 1, 0);
    send(1,0,1,2'd1,0); send(1,0,1,2'd2,0); send(1,0,1,2'd3,1);
    send(1,0,1,2'd3,1); send(1,0,1,2'd3,1);
    check("sat_cnt", match_cnt, 3);
    drained("sat_drain");

    // Invalid lengths park in idle.
    cfg(8'b1, 0, 1, 0);
    send(1,0,0,0,0); send(1,0,0,0,0); send(0,0,0,0,0); send(1,0,0,0,0);
    check("len0_armed", armed, 0);
    check("len0_cnt", match_cnt, 0);
    cfg(8'hFF, 9, 1, 0);
    for (int i = 0; i < 9; i++) send(1,0,0,0,0);
    check("len9_armed", armed, 0);
    drained("inval_drain");

    // Reset mid-stream discards partial history and configuration.
    cfg(8'b0011, 4, 1, 0);
    send(0,0,0,0,0); send(0,0,0,0,0); send(1,0,0,0,0);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    send(1,0,0,0,0);
    check("midrst_cnt", match_cnt, 0);
    check("midrst_armed", armed, 0);
    cfg(8'b0011, 4, 1, 0);
    send(0,0,0,0,0); send(0,0,0,0,0); send(1,0,0,0,0); send(1,0,1,2'd1,0);
    drained("midrst_drain");

    // Reconfigure mid-stream; the bit presented with cfg_we is dropped.
    cfg(8'b0011, 4, 1, 0);
    send(0,0,0,0,0); send(0,0,0,0,0); send(1,0,0,0,0);
    cfg(8'b0011, 4, 1, 1);
    send(1,0,0,0,0);
    check("midcfg_cnt", match_cnt, 0);
    send(0,0,0,0,0); send(0,0,0,0,0); send(1,0,0,0,0); send(1,0,1,2'd1,0);
    check("midcfg_final", match_cnt, 1);
    drained("midcfg_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_pager_param.md
Name: seq_pager_param

Overview:
- Parametrised serial pattern-detecting pager: samples one bit per accepted cycle, compares the most recent pat_len bits against a runtime-programmable pattern, and pulses z on each match.
- Adds features the fixed single-pattern pager does not have: a runtime pattern and length, an overlap/non-overlap mode and a saturating match counter.
- Also adds a sticky page alert raised after THRESH matches and cleared by acknowledge.
- Sits between the serial line receiver and the alert/display logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 4, width of match_cnt.
- THRESH, 3, match count that raises page (1..2^CNT_W-1).
- LEN_W, $clog2(MAX_LEN+1), width of pat_len (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cfg_we  in  1  load pat/pat_len/overlap; clears history and counter.
- pat  in  MAX_LEN  pattern; bit pat_len-1 is received first, bit 0 last.
- pat_len  in  LEN_W  active pattern length.
- overlap  in  1  1 = overlapping matches allowed.
- in_valid  in  1  x is sampled this cycle.
- x  in  1  serial data bit.
- ack  in  1  acknowledge page; clears counter.
- z  out  1  one-cycle match pulse.
- match_cnt  out  CNT_W  matches since last ack/cfg_we (saturating).
- page  out  1  sticky alert.
- armed  out  1  configuration is valid and history is full.

Behaviour:
- Reset: one clock, clk; reset is synchronous and active-low (rst_n). At a rising edge with rst_n=0, all state clears: state=S_IDLE, z=0, match_cnt=0, page=0, armed=0, history=0, fill=0, config registers=0.
- Config:
  - On cfg_we=1, latch pat, pat_len and overlap; clear history, fill, match_cnt and page.
  - If 1<=pat_len<=MAX_LEN, go to S_FILL; otherwise go to S_IDLE, where z never asserts.
  - cfg_we has priority over in_valid and ack in the same cycle; the bit presented that cycle is discarded.
- History:
  - MAX_LEN-bit shift register; each in_valid shifts x into bit 0.
  - fill counts accepted bits, saturating at pat_len.
  - Inputs with in_valid=0 change nothing.
- FSM states: S_IDLE, S_FILL, S_HUNT, S_PAGE.
  - S_IDLE -> S_FILL only on cfg_we with a valid length.
  - S_FILL -> S_HUNT when fill reaches pat_len. A match is possible on the bit that fills the history.
  - S_HUNT -> S_PAGE when a match makes match_cnt equal THRESH.
  - S_PAGE -> S_HUNT on ack, or S_FILL if history was cleared by a non-overlap match in the same cycle.
- Match: the low pat_len bits of history (including the bit being accepted) equal the low pat_len bits of pat, with in_valid=1 in S_FILL-with-full-history, S_HUNT or S_PAGE.
- Match timing: z is registered and high for exactly the one cycle after the edge that accepted the completing bit. match_cnt and page update on that same edge. Latency is 1 cycle.
- Non-overlap mode (overlap=0): on a match, history and fill clear and the FSM goes to S_FILL (page stays set if in S_PAGE). The next match needs pat_len fresh bits. Overlap mode keeps the history.
- Counter: increments on each match and saturates at 2^CNT_W-1, with no wrap. page sets when match_cnt reaches THRESH and stays set until ack, cfg_we or reset.
- ack:
  - Clears match_cnt and page and leaves history untouched.
  - ack with a simultaneous match: the clear applies first, then the match counts, giving match_cnt=1. page is then set only if THRESH==1.
  - ack in S_IDLE/S_FILL/S_HUNT only clears the counter.
- armed = 1 in S_HUNT and S_PAGE.
- Reset mid-stream discards partial history; configuration must be reloaded after reset.

Decomposition:
- Package seq_pager_pkg: FSM state enum (S_IDLE, S_FILL, S_HUNT, S_PAGE) and a LEN_W helper function.
- One sub-module, pat_match_shift: history shift register, fill counter and length-masked compare, producing a combinational hit.
- The FSM, counter and page logic stay in the top level.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then 1 with no cfg_we; stream 0,0,1,1 -> z never 1, match_cnt=0, page=0, armed=0.
- Basic match: cfg pat=0011, pat_len=4, overlap=1; stream 0,0,1,1 -> z=1 for one cycle after the 4th bit, match_cnt=1, armed=1 after the 4th bit.
- Overlap vs non-overlap: pat=1001, pat_len=4; stream 1,0,0,1,0,0,1.
  - overlap=1 -> z pulses after bits 4 and 7, match_cnt=2.
  - overlap=0 -> single pulse after bit 4, match_cnt=1.
- Page/ack: THRESH=3, pat=01, pat_len=2, overlap=1; stream 0,1,0,1,0,1 -> page rises with the 3rd match (match_cnt=3).
  - ack -> page=0, match_cnt=0.
  - ack asserted in the same cycle as a 4th match -> match_cnt=1, page=0.
- Saturation/invalid config: CNT_W=2, 5 matches -> match_cnt holds 3. cfg pat_len=0 -> S_IDLE, no z for any stream.
- Mid-stream disruption: reset or cfg_we after 0,0,1 of pattern 0011, then 1 -> no match. A full 0,0,1,1 afterwards gives one z pulse.
